// File: rtl/car_uart_pkg.sv
// Shared definitions for the car command UART link: frame marker, command bit
// positions, transmitter state encoding and the command-byte packing rule.
package car_uart_pkg;

    localparam logic [1:0] UART_MARKER = 2'b01;

    localparam int CMD_FWD     = 0;
    localparam int CMD_BACK    = 1;
    localparam int CMD_LEFT    = 2;
    localparam int CMD_RIGHT   = 3;
    localparam int CMD_PLACE   = 4;
    localparam int CMD_DESTROY = 5;
    localparam int NUM_CMDS    = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // A powered-down car always reports the all-stop byte.
    function automatic logic [7:0] pack_cmd(input logic en, input logic [NUM_CMDS-1:0] cmd);
        return {UART_MARKER, (en ? cmd : {NUM_CMDS{1'b0}})};
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer shared by the UART transmitter and receiver: counts
// 0..CLKS_PER_BIT-1 while running and flags the last cycle of each bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = run && !clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/car_cmd_uart_tx.sv
// Car command transmitter: synchronizes the drive/barrier commands, packs them
// into one byte and sends it as an 8N1 frame on change or on refresh expiry.
module car_cmd_uart_tx
    import car_uart_pkg::*;
#(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int BAUD           = 9600,
    parameter int REFRESH_CYCLES = 10_000_000
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic enable,
    input  logic move_forward,
    input  logic move_backward,
    input  logic turn_left,
    input  logic turn_right,
    input  logic place_barrier,
    input  logic destroy_barrier,
    output logic tx,
    output logic busy,
    output logic frame_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam int SYNC_EN = NUM_CMDS;
    localparam logic [7:0] ALL_STOP = {UART_MARKER, 6'b0};

    logic [NUM_CMDS:0] raw_in;
    logic [NUM_CMDS:0] sync1_q, sync2_q;
    logic [7:0]        cur;

    tx_state_t   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  last_sent_q, last_sent_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [RW-1:0] refresh_q, refresh_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        baud_tick;
    logic        refresh_expired;

    always_comb begin
        raw_in              = '0;
        raw_in[CMD_FWD]     = move_forward;
        raw_in[CMD_BACK]    = move_backward;
        raw_in[CMD_LEFT]    = turn_left;
        raw_in[CMD_RIGHT]   = turn_right;
        raw_in[CMD_PLACE]   = place_barrier;
        raw_in[CMD_DESTROY] = destroy_barrier;
        raw_in[SYNC_EN]     = enable;
    end

    assign cur             = pack_cmd(sync2_q[SYNC_EN], sync2_q[NUM_CMDS-1:0]);
    assign refresh_expired = (refresh_q == REFRESH_LAST);

    // Counter is held at zero in IDLE so every bit starts on a fresh period.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .clear  (state_q == IDLE),
        .run    (state_q != IDLE),
        .tick   (baud_tick)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        last_sent_d = last_sent_q;
        bit_idx_d   = bit_idx_q;
        refresh_d   = refresh_q;

        case (state_q)
            IDLE: begin
                // A change and an expiry together still launch only one frame.
                if ((cur != last_sent_q) || refresh_expired) begin
                    state_d     = START;
                    shift_d     = cur;
                    last_sent_d = cur;
                    refresh_d   = '0;
                end else if (!refresh_expired) begin
                    refresh_d = refresh_q + RW'(1);
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line outputs follow the current state one cycle later, glitch-free.
    always_comb begin
        tx_d         = 1'b1;
        busy_d       = (state_q != IDLE);
        frame_done_d = (state_q == STOP) && baud_tick;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            state_q      <= IDLE;
            shift_q      <= '0;
            last_sent_q  <= ALL_STOP;
            bit_idx_q    <= '0;
            refresh_q    <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            sync1_q      <= raw_in;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            shift_q      <= shift_d;
            last_sent_q  <= last_sent_d;
            bit_idx_q    <= bit_idx_d;
            refresh_q    <= refresh_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_car_cmd_uart_tx.sv
// Bench for car_cmd_uart_tx: cycle-accurate line model from the frame rules,
// a vector table of command patterns, hand sequences and random stimulus.
module tb_car_cmd_uart_tx;

    localparam int CPB     = 16;
    localparam int REFRESH = 400;
    localparam int FRAME   = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [5:0] cmd;
    logic       tx, busy, frame_done;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    car_cmd_uart_tx #(
        .CLK_FREQ(16),
        .BAUD(1),
        .REFRESH_CYCLES(REFRESH)
    ) dut (
        .sys_clk        (clk),
        .rst_n          (rst_n),
        .enable         (en),
        .move_forward   (cmd[0]),
        .move_backward  (cmd[1]),
        .turn_left      (cmd[2]),
        .turn_right     (cmd[3]),
        .place_barrier  (cmd[4]),
        .destroy_barrier(cmd[5]),
        .tx             (tx),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // pos = cycle index inside the frame (0..159), -1 when the line is idle.
    typedef struct {
        int         pos;
        logic [7:0] fb;
        logic [7:0] last;
        int         idle;
    } model_t;

    model_t     m;
    logic [6:0] h1, h2;
    logic       exp_tx, exp_busy, exp_fd;

    function automatic logic [7:0] byte_of(input logic [6:0] r);
        return {2'b01, (r[6] ? r[5:0] : 6'b0)};
    endfunction

    function automatic logic line_of(input model_t s);
        if (s.pos < 0)          return 1'b1;
        if (s.pos < CPB)        return 1'b0;
        if (s.pos < 9 * CPB)    return s.fb[(s.pos - CPB) / CPB];
        return 1'b1;
    endfunction

    function automatic model_t step(input model_t s, input logic [7:0] c);
        model_t r = s;
        if (s.pos < 0) begin
            if (c != s.last || s.idle == REFRESH - 1) begin
                r.pos = 0; r.fb = c; r.last = c; r.idle = 0;
            end else if (s.idle < REFRESH - 1) begin
                r.idle = s.idle + 1;
            end
        end else if (s.pos == FRAME - 1) begin
            r.pos = -1;
        end else begin
            r.pos = s.pos + 1;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m        <= '{-1, 8'h40, 8'h40, 0};
            h1       <= '0;
            h2       <= '0;
            exp_tx   <= 1'b1;
            exp_busy <= 1'b0;
            exp_fd   <= 1'b0;
        end else begin
            exp_tx   <= line_of(m);
            exp_busy <= (m.pos >= 0);
            exp_fd   <= (m.pos == FRAME - 1);
            m        <= step(m, byte_of(h2));
            h2       <= h1;
            h1       <= {en, cmd};
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("tx_cycle", tx, exp_tx);
            check("busy_cycle", busy, exp_busy);
            check("frame_done_cycle", frame_done, exp_fd);
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input int limit, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < limit) begin
            @(negedge clk);
            n++;
            if (tx === 1'b0) ok = 1'b1;
        end
    endtask

    // Entered on frame cycle 1 (first low sample); returns on cycle 160.
    task automatic recv_byte(input string nm, input logic [7:0] expv);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            tick(i == 0 ? CPB + CPB / 2 - 1 : CPB);
            b[i] = tx;
        end
        tick(CPB);
        check({nm, "_stop"}, tx, 1);
        tick(CPB / 2);
        check({nm, "_byte"}, b, expv);
        check({nm, "_done"}, frame_done, 1);
    endtask

    task automatic count_lows(input int n, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
    endtask

    typedef struct {
        logic       en;
        logic [5:0] cmd;
        logic       frame;
        logic [7:0] byte_exp;
    } vec_t;

    initial begin
        vec_t tbl[12];
        int   n, bad;
        bit   ok;

        tbl[0]  = '{1'b1, 6'b000001, 1'b1, 8'h41};
        tbl[1]  = '{1'b1, 6'b000010, 1'b1, 8'h42};
        tbl[2]  = '{1'b1, 6'b000100, 1'b1, 8'h44};
        tbl[3]  = '{1'b1, 6'b001000, 1'b1, 8'h48};
        tbl[4]  = '{1'b1, 6'b010000, 1'b1, 8'h50};
        tbl[5]  = '{1'b1, 6'b100000, 1'b1, 8'h60};
        tbl[6]  = '{1'b1, 6'b010101, 1'b1, 8'h55};
        tbl[7]  = '{1'b0, 6'b010101, 1'b1, 8'h40};
        tbl[8]  = '{1'b0, 6'b111111, 1'b0, 8'h00};
        tbl[9]  = '{1'b1, 6'b111111, 1'b1, 8'h7F};
        tbl[10] = '{1'b1, 6'b000000, 1'b1, 8'h40};
        tbl[11] = '{1'b1, 6'b000000, 1'b0, 8'h00};

        rst_n = 1'b0;
        en    = 1'b1;
        cmd   = '0;
        tick(3);
        #1 check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        tick(1);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Static all-stop after reset: nothing to send.
        count_lows(300, bad);
        check("idle_after_reset", bad, 0);

        // First command frame and its latency.
        cmd = 6'b000001;
        wait_start(20, n, ok);
        check("fwd_seen", ok, 1);
        check("start_latency", n, 4);
        recv_byte("fwd", 8'h41);

        // Refresh resend after exactly REFRESH idle-high cycles.
        wait_start(600, n, ok);
        check("refresh_seen", ok, 1);
        check("refresh_gap", n, REFRESH + 1);
        recv_byte("refresh", 8'h41);

        // Mid-frame glitch that reverts before IDLE is never sent.
        wait_start(600, n, ok);
        check("refresh2_seen", ok, 1);
        tick(40);
        cmd = 6'b000101;
        tick(60);
        cmd = 6'b000001;
        tick(59);
        wait_start(100, n, ok);
        check("no_frame_after_revert", ok, 0);
        wait_start(600, n, ok);
        check("refresh_after_revert", n, REFRESH - 100 + 1);

        // Mid-frame change that persists goes out after a single idle cycle.
        tick(40);
        cmd = 6'b010101;
        tick(119);
        wait_start(10, n, ok);
        check("back_to_back_gap", n, 2);
        recv_byte("left_place", 8'h55);

        // Enable drop sends all-stop; commands are ignored while disabled.
        cmd = 6'b000001;
        wait_start(20, n, ok);
        check("fwd2_seen", ok, 1);
        recv_byte("fwd2", 8'h41);
        en = 1'b0;
        wait_start(20, n, ok);
        check("stop_latency", n, 4);
        recv_byte("stop", 8'h40);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            cmd = 6'($urandom);
            for (int j = 0; j < 15; j++) begin
                @(negedge clk);
                if (tx !== 1'b1) bad++;
            end
        end
        check("disabled_no_frames", bad, 0);

        // Async reset in data bit 3 abandons the frame.
        en  = 1'b1;
        cmd = 6'b000001;
        wait_start(20, n, ok);
        check("fwd3_seen", ok, 1);
        tick(30);
        cmd = 6'b000000;
        tick(42);
        check("before_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_tx", tx, 1);
        check("reset_mid_busy", busy, 0);
        tick(3);
        rst_n = 1'b1;
        count_lows(300, bad);
        check("quiet_after_reset", bad, 0);

        // Vector table.
        for (int i = 0; i < 12; i++) begin
            en  = tbl[i].en;
            cmd = tbl[i].cmd;
            wait_start(100, n, ok);
            check($sformatf("vec%0d_frame", i), ok, tbl[i].frame);
            if (ok) recv_byte($sformatf("vec%0d", i), tbl[i].byte_exp);
        end

        // Random command activity against the line model.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 2) en = ~en;
            cmd = 6'($urandom);
            tick($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : $urandom_range(1, 200));
        end
        tick(2 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/car_cmd_uart_tx.md
# car_cmd_uart_tx

Serial command transmitter from the car controller to the simulated device. It packs the six drive and barrier commands into one byte and sends it on `tx` as a UART 8N1 frame. A frame is sent whenever the command set changes, and again at a fixed refresh interval. It is the outbound counterpart to the detector frames received on `rx`, and sits between the mode-muxed command signals and the `tx` pin.

## Interface
- `CLK_FREQ`, 100_000_000, sys_clk frequency in Hz
- `BAUD`, 9600, line rate; `CLKS_PER_BIT = CLK_FREQ/BAUD`, integer division, must be ≥ 4
- `REFRESH_CYCLES`, 10_000_000, sys_clk cycles between forced resends (100 ms)

Ports:
- `sys_clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `enable` input 1: car powered (power_now). Low forces the command byte to all-stop.
- `move_forward` input 1: command, asynchronous level.
- `move_backward` input 1: command, asynchronous level.
- `turn_left` input 1: command, asynchronous level.
- `turn_right` input 1: command, asynchronous level.
- `place_barrier` input 1: command, asynchronous level.
- `destroy_barrier` input 1: command, asynchronous level.
- `tx` output 1: serial line; idle high.
- `busy` output 1: high from start bit through stop bit.
- `frame_done` output 1: one-cycle pulse on the last cycle of the stop bit.

## Operation
- All six command inputs and `enable` pass through a 2-flop synchronizer.
- Command byte `cur`, built from synchronized values:
  - bit0 forward, bit1 backward, bit2 left, bit3 right, bit4 place, bit5 destroy.
  - bits[7:6] = 2'b01 as a frame marker.
  - When synchronized `enable` = 0, bits[5:0] are forced to 0.
- Register `last_sent` holds the last transmitted byte. Reset value is 8'h40 (the all-stop byte).
- State machine: IDLE → START → DATA → STOP → IDLE.
- IDLE:
  - Leave IDLE if `cur != last_sent` or the refresh counter has expired.
  - On leaving: load `cur` into the shift register and into `last_sent`, clear the refresh counter, go to START.
- START: `tx` = 0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index counts 0..7.
- STOP: `tx` = 1 for CLKS_PER_BIT cycles; `frame_done` pulses on the final cycle; then return to IDLE.
- Refresh counter:
  - Counts sys_clk cycles only while in IDLE; saturates at REFRESH_CYCLES-1.
  - "Expired" means the counter equals REFRESH_CYCLES-1.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Reloads to 0 on every state or bit boundary.
  - Counts 0..CLKS_PER_BIT-1 and wraps.

## Timing
- Reset values: `tx`=1, `busy`=0, `frame_done`=0, state IDLE, refresh counter 0, `last_sent`=8'h40.
- Latency: an input change sampled at edge N drives `tx` low after edge N+3 (two synchronizer stages, one IDLE decision).
- Frame length is exactly 10×CLKS_PER_BIT cycles; `busy` is high for all of them.
- IDLE → START takes one cycle, so the minimum gap between frames is 1 cycle of idle-high.
- Command change during a frame:
  - The frame in flight is unaffected.
  - The new `cur` is compared on the first IDLE cycle and transmitted then if still different.
  - Intermediate values that revert before IDLE are never sent.
- Change and refresh expiry in the same cycle: exactly one frame is sent.
- `enable` falling: `cur` becomes 8'h40, so a stop frame follows unless 8'h40 was the last byte sent.
- `rst_n` asserted mid-frame: `tx`=1 at once, asynchronously; the partial frame is abandoned.

## Structure
- Shared package `car_uart_pkg`:
  - `UART_MARKER` = 2'b01.
  - Command bit-index localparams: `CMD_FWD`=0, `CMD_BACK`=1, `CMD_LEFT`=2, `CMD_RIGHT`=3, `CMD_PLACE`=4, `CMD_DESTROY`=5.
  - State enum `tx_state_t` {IDLE, START, DATA, STOP}.
- Sub-module `uart_baud_tick`:
  - Parameter CLKS_PER_BIT; inputs `clear` and `run`; output `tick` on count CLKS_PER_BIT-1.
  - The future receiver reuses the same block.

## Test plan
Bench parameters: CLK_FREQ=16, BAUD=1 (16 cycles/bit), REFRESH_CYCLES=400.
- Reset, inputs 0, `enable`=1, wait 300 cycles → `tx` stays 1, `busy`=0, no frame.
- Raise `move_forward` → start bit 3 cycles later; data LSB-first = 8'h41; stop bit; `frame_done` pulses at cycle 160 of the frame.
- Hold inputs static after a frame → next 8'h41 frame starts exactly 400 IDLE cycles after the previous frame ends.
- Set `turn_left` mid-frame and clear it before STOP ends → no second frame. Set `turn_left`+`place_barrier` mid-frame and hold → 8'h55 frame starts 1 cycle after IDLE is re-entered.
- With 8'h41 last sent, drop `enable` → 8'h40 frame follows; toggling commands while `enable`=0 produces no frames.
- Assert `rst_n`=0 during DATA bit 3 → `tx`=1 in the same cycle; after release, no frame until an input change or refresh expiry.
